// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between an instruction fetch port (A)
// and a load/store port (B); partial-word stores are done as a read-modify-write.
`timescale 1ns/1ps
module ram_arbiter #(
    parameter int unsigned ANCHO = 32,
    parameter int unsigned LARGO = 1024,
    localparam int unsigned AW   = $clog2(LARGO),
    localparam int unsigned NB   = ANCHO / 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_req,
    input  logic [AW-1:0]    a_addr,
    output logic             a_gnt,
    output logic             a_rvalid,
    output logic [ANCHO-1:0] a_rdata,
    input  logic             b_req,
    input  logic             b_we,
    input  logic [NB-1:0]    b_be,
    input  logic [AW-1:0]    b_addr,
    input  logic [ANCHO-1:0] b_wdata,
    output logic             b_gnt,
    output logic             b_rvalid,
    output logic [ANCHO-1:0] b_rdata,
    output logic             ram_we,
    output logic [AW-1:0]    ram_addr,
    output logic [ANCHO-1:0] ram_din,
    input  logic [ANCHO-1:0] ram_dout
);

    typedef enum logic [0:0] {StIdle, StRmwWr} state_e;

    state_e           state_q;
    logic             ptr_q;  // 0: A has priority, 1: B has priority
    logic [AW-1:0]    addr_q;
    logic [ANCHO-1:0] wdata_q;
    logic [NB-1:0]    be_q;
    logic [ANCHO-1:0] old_q;

    logic             a_win;
    logic             b_win;
    logic             b_partial;
    logic [ANCHO-1:0] merged;

    assign a_win     = a_req && (!b_req || !ptr_q);
    assign b_win     = b_req && (!a_req || ptr_q);
    assign b_partial = (b_be != '0) && (b_be != '1);

    always_comb begin
        merged = old_q;
        for (int i = 0; i < int'(NB); i++) begin
            if (be_q[i]) merged[8*i +: 8] = wdata_q[8*i +: 8];
        end
    end

    always_comb begin
        a_gnt    = 1'b0;
        b_gnt    = 1'b0;
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        case (state_q)
            StIdle: begin
                if (a_win) begin
                    a_gnt    = 1'b1;
                    ram_addr = a_addr;
                end else if (b_win) begin
                    if (!b_we) begin
                        b_gnt    = 1'b1;
                        ram_addr = b_addr;
                    end else if (b_be == '1) begin
                        b_gnt    = 1'b1;
                        ram_we   = 1'b1;
                        ram_addr = b_addr;
                        ram_din  = b_wdata;
                    end else if (b_be == '0) begin
                        b_gnt = 1'b1;
                    end else begin
                        // Read phase of RMW: fetch the old word, grant comes next cycle
                        ram_addr = b_addr;
                    end
                end
            end
            StRmwWr: begin
                b_gnt    = 1'b1;
                ram_we   = 1'b1;
                ram_addr = addr_q;
                ram_din  = merged;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            ptr_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            old_q    <= '0;
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
            a_rdata  <= '0;
            b_rdata  <= '0;
        end else begin
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (a_win) begin
                        a_rdata  <= ram_dout;
                        a_rvalid <= 1'b1;
                        ptr_q    <= 1'b1;
                    end else if (b_win) begin
                        if (!b_we) begin
                            b_rdata  <= ram_dout;
                            b_rvalid <= 1'b1;
                            ptr_q    <= 1'b0;
                        end else if (b_partial) begin
                            old_q   <= ram_dout;
                            addr_q  <= b_addr;
                            wdata_q <= b_wdata;
                            be_q    <= b_be;
                            state_q <= StRmwWr;
                        end else begin
                            ptr_q <= 1'b0;
                        end
                    end
                end
                StRmwWr: begin
                    state_q <= StIdle;
                    ptr_q   <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: directed traffic against a behavioural RAM model.
`timescale 1ns/1ps
module tb_ram_arbiter;

    localparam int unsigned ANCHO = 32;
    localparam int unsigned LARGO = 1024;
    localparam int unsigned AW    = $clog2(LARGO);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             a_req;
    logic [AW-1:0]    a_addr;
    logic             a_gnt;
    logic             a_rvalid;
    logic [ANCHO-1:0] a_rdata;
    logic             b_req;
    logic             b_we;
    logic [3:0]       b_be;
    logic [AW-1:0]    b_addr;
    logic [ANCHO-1:0] b_wdata;
    logic             b_gnt;
    logic             b_rvalid;
    logic [ANCHO-1:0] b_rdata;
    logic             ram_we;
    logic [AW-1:0]    ram_addr;
    logic [ANCHO-1:0] ram_din;
    logic [ANCHO-1:0] ram_dout;

    logic [ANCHO-1:0] mem [LARGO];
    logic [ANCHO-1:0] exp_a [$];
    logic [ANCHO-1:0] exp_b [$];
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ram_arbiter #(.ANCHO(ANCHO), .LARGO(LARGO)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_addr(a_addr), .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    // RAM model: async read, sync write
    assign ram_dout = mem[ram_addr];
    initial begin
        for (int i = 0; i < int'(LARGO); i++) mem[i] = '0;
        mem[0] = 32'hCAFE0000;
        mem[2] = 32'h02020202;
        mem[4] = 32'h44444444;
        mem[5] = 32'hDEADBEEF;
        mem[7] = 32'h07070707;
        mem[9] = 32'hAABBCCDD;
        forever begin
            @(posedge clk);
            if (ram_we) mem[ram_addr] <= ram_din;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Response monitor
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (a_rvalid) begin
                if (exp_a.size() == 0) chk("a_unexpected_rvalid", 32'd1, 32'd0);
                else chk("a_rdata", a_rdata, exp_a.pop_front());
            end
            if (b_rvalid) begin
                if (exp_b.size() == 0) chk("b_unexpected_rvalid", 32'd1, 32'd0);
                else chk("b_rdata", b_rdata, exp_b.pop_front());
            end
        end
    end

    initial begin
        rst_n = 1'b0; a_req = 0; a_addr = '0; b_req = 0; b_we = 0; b_be = '0;
        b_addr = '0; b_wdata = '0;
        repeat (2) @(posedge clk);
        #4;
        chk("rst_a_rvalid", a_rvalid, 0);
        chk("rst_b_rvalid", b_rvalid, 0);
        chk("rst_a_rdata", a_rdata, 0);
        chk("rst_b_rdata", b_rdata, 0);
        chk("rst_ram_we", ram_we, 0);
        step();
        rst_n = 1'b1;

        // Single A read
        step();
        a_req = 1; a_addr = 5;
        #3;
        chk("t1_a_gnt", a_gnt, 1);
        chk("t1_b_gnt", b_gnt, 0);
        exp_a.push_back(32'hDEADBEEF);
        step();
        a_req = 0;
        #3 chk("t1_a_rvalid_hi", a_rvalid, 1);
        step();
        #3 chk("t1_a_rvalid_lo", a_rvalid, 0);

        // Round robin from reset
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        a_req = 1; a_addr = 7; b_req = 1; b_we = 0; b_addr = 7; b_be = 4'hF;
        for (int k = 0; k < 4; k++) begin
            #3;
            chk("rr_a_gnt", a_gnt, 32'(k % 2 == 0));
            chk("rr_b_gnt", b_gnt, 32'(k % 2 == 1));
            if (k > 0) begin
                chk("rr_a_rvalid", a_rvalid, 32'(k % 2 == 1));
                chk("rr_b_rvalid", b_rvalid, 32'(k % 2 == 0));
            end
            if (k % 2 == 0) exp_a.push_back(32'h07070707);
            else exp_b.push_back(32'h07070707);
            step();
        end
        a_req = 0; b_req = 0;
        #3;
        chk("rr_last_b_rvalid", b_rvalid, 1);
        chk("rr_last_a_rvalid", a_rvalid, 0);

        // Full write then A reads it back
        step();
        b_req = 1; b_we = 1; b_be = 4'hF; b_addr = 3; b_wdata = 32'h12345678;
        #3;
        chk("fw_b_gnt", b_gnt, 1);
        chk("fw_ram_we", ram_we, 1);
        chk("fw_ram_addr", 32'(ram_addr), 3);
        chk("fw_ram_din", ram_din, 32'h12345678);
        step();
        b_req = 0; a_req = 1; a_addr = 3;
        #3 chk("fw_a_gnt", a_gnt, 1);
        exp_a.push_back(32'h12345678);

        // Partial write with A contending
        step();
        b_req = 1; b_we = 1; b_be = 4'b0101; b_addr = 9; b_wdata = 32'h11223344;
        a_req = 1; a_addr = 0;
        #3;
        chk("pw1_b_gnt", b_gnt, 0);
        chk("pw1_a_gnt", a_gnt, 0);
        chk("pw1_ram_we", ram_we, 0);
        chk("pw1_ram_addr", 32'(ram_addr), 9);
        step();
        #3;
        chk("pw2_b_gnt", b_gnt, 1);
        chk("pw2_a_gnt", a_gnt, 0);
        chk("pw2_ram_we", ram_we, 1);
        chk("pw2_ram_addr", 32'(ram_addr), 9);
        chk("pw2_ram_din", ram_din, 32'hAA22CC44);
        step();
        b_req = 0;
        #3;
        chk("pw3_a_gnt", a_gnt, 1);
        chk("pw3_mem9", mem[9], 32'hAA22CC44);
        exp_a.push_back(32'hCAFE0000);

        // Null write
        step();
        a_req = 0;
        b_req = 1; b_we = 1; b_be = 4'h0; b_addr = 2; b_wdata = 32'hFFFFFFFF;
        #3;
        chk("nw_b_gnt", b_gnt, 1);
        chk("nw_ram_we", ram_we, 0);
        step();
        b_req = 0;
        #3;
        chk("nw_mem2", mem[2], 32'h02020202);

        // Reset during the RMW write cycle
        step();
        b_req = 1; b_we = 1; b_be = 4'b0011; b_addr = 4; b_wdata = 32'h0;
        #3 chk("rr_rmw1_b_gnt", b_gnt, 0);
        step();
        #1;
        rst_n = 1'b0;
        b_req = 0;
        #1;
        chk("rmw_rst_ram_we", ram_we, 0);
        chk("rmw_rst_b_gnt", b_gnt, 0);
        step();
        rst_n = 1'b1;
        #3;
        chk("rmw_rst_mem4", mem[4], 32'h44444444);
        chk("rmw_rst_a_rvalid", a_rvalid, 0);
        chk("rmw_rst_b_rvalid", b_rvalid, 0);
        chk("rmw_rst_idle_we", ram_we, 0);
        step();
        b_req = 1; b_we = 0; b_addr = 4;
        #3 chk("post_rst_b_gnt", b_gnt, 1);
        exp_b.push_back(32'h44444444);
        step();
        b_req = 0;
        repeat (3) step();

        chk("drain_a", exp_a.size(), 0);
        chk("drain_b", exp_b.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
